// File: rtl/eth_mac_rx.sv
// Ethernet MAC receive path: preamble/SFD strip, FCS removal via a 5-byte delay line,
// CRC-32 residue check, length policing and saturating frame statistics.
module eth_mac_rx #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phy_rx_dv,
  input  logic [7:0]       phy_rx_data,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_last,
  output logic             rx_err,
  output logic             rx_busy,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_len_err
);

  localparam int unsigned    LenW       = 11;
  localparam int unsigned    Depth      = 5;
  localparam logic [LenW-1:0] MinLen    = LenW'(MIN_FRAME);
  localparam logic [LenW-1:0] OverLen   = LenW'(MAX_FRAME + 1);
  localparam logic [31:0]    CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0]    CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0]    CrcResidue = 32'hDEBB_20E3;
  localparam logic [7:0]     Preamble   = 8'h55;
  localparam logic [7:0]     Sfd        = 8'hD5;

  typedef enum logic [1:0] {StDrop, StIdle, StPreamble, StData} state_e;

  state_e          state;
  logic [LenW-1:0] len;
  logic [31:0]     crc;
  logic [7:0]      line [Depth];
  logic [2:0]      fill;

  logic [LenW-1:0] len_inc;
  logic [31:0]     crc_upd;
  logic            line_full;
  logic            crc_good;
  logic            short_frame;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    len_inc     = len + LenW'(1);
    crc_upd     = crc_byte(crc, phy_rx_data);
    line_full   = (fill == 3'(Depth));
    crc_good    = (crc == CrcResidue);
    short_frame = (len < MinLen);
  end

  assign rx_busy = (state == StPreamble) || (state == StData);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StDrop;
      len         <= '0;
      crc         <= CrcInit;
      fill        <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      rx_err      <= 1'b0;
      cnt_ok      <= '0;
      cnt_crc_err <= '0;
      cnt_len_err <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        line[i] <= '0;
      end
    end else begin
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      rx_err   <= 1'b0;

      unique case (state)
        StDrop: begin
          if (!phy_rx_dv) begin
            state <= StIdle;
          end
        end

        StIdle, StPreamble: begin
          if (!phy_rx_dv) begin
            state <= StIdle;
          end else if (phy_rx_data == Preamble) begin
            state <= StPreamble;
          end else if (phy_rx_data == Sfd) begin
            state <= StData;
            len   <= '0;
            crc   <= CrcInit;
            fill  <= '0;
          end else begin
            state <= StDrop;
          end
        end

        StData: begin
          if (phy_rx_dv) begin
            len     <= len_inc;
            crc     <= crc_upd;
            line[0] <= phy_rx_data;
            for (int unsigned i = 1; i < Depth; i++) begin
              line[i] <= line[i-1];
            end
            if (!line_full) begin
              fill <= fill + 3'd1;
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= line[Depth-1];
            end
            // Oversize: terminate the stream now and ignore the remainder of the frame.
            if (len_inc == OverLen) begin
              rx_valid    <= 1'b1;
              rx_last     <= 1'b1;
              rx_err      <= 1'b1;
              rx_data     <= line[Depth-1];
              cnt_len_err <= sat_inc(cnt_len_err);
              state       <= StDrop;
            end
          end else begin
            // The 4 bytes left in the line are the FCS and are discarded.
            if (line_full) begin
              rx_valid <= 1'b1;
              rx_last  <= 1'b1;
              rx_err   <= short_frame || !crc_good;
              rx_data  <= line[Depth-1];
            end
            if (short_frame) begin
              cnt_len_err <= sat_inc(cnt_len_err);
            end else if (!crc_good) begin
              cnt_crc_err <= sat_inc(cnt_crc_err);
            end else begin
              cnt_ok <= sat_inc(cnt_ok);
            end
            state <= StIdle;
          end
        end

        default: state <= StDrop;
      endcase
    end
  end

  a_last_needs_valid: assert property (@(posedge clk) disable iff (reset) rx_last |-> rx_valid);
  a_err_needs_last:   assert property (@(posedge clk) disable iff (reset) rx_err |-> rx_last);

endmodule

// File: tb/tb_eth_mac_rx.sv
// Scoreboard bench for eth_mac_rx: frames with generated FCS, expected beats queued at drive
// time and matched against the output stream; counters tracked with a saturating model.
module tb_eth_mac_rx;

  localparam int CntW   = 4;
  localparam int CntMax = 15;
  localparam int MinF   = 64;
  localparam int MaxF   = 1518;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            phy_rx_dv = 1'b0;
  logic [7:0]      phy_rx_data = 8'h00;
  logic [7:0]      rx_data;
  logic            rx_valid, rx_last, rx_err, rx_busy;
  logic [CntW-1:0] cnt_ok, cnt_crc_err, cnt_len_err;

  eth_mac_rx #(.MIN_FRAME(MinF), .MAX_FRAME(MaxF), .CNT_W(CntW)) dut (
    .clk         (clk),
    .reset       (reset),
    .phy_rx_dv   (phy_rx_dv),
    .phy_rx_data (phy_rx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_err      (rx_err),
    .rx_busy     (rx_busy),
    .cnt_ok      (cnt_ok),
    .cnt_crc_err (cnt_crc_err),
    .cnt_len_err (cnt_len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      e;
  logic [7:0] frm[$];
  int         total = 0;
  int         bad = 0;
  int         exp_ok = 0, exp_crc = 0, exp_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = ((c[0] ^ b[i]) ? 32'hEDB88320 : 32'h0) ^ (c >> 1);
    end
    return c;
  endfunction

  // Payload of n_data bytes starting at value base, standard FCS appended LSB first.
  task automatic make_frame(input int n_data, input int base, input int flip_idx);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_data; i++) begin
      b = 8'(i + base);
      frm.push_back(b);
      c = crc_step(c, b);
    end
    fcs = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'h01;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk);
    #1;
    phy_rx_dv   = dv;
    phy_rx_data = d;
  endtask

  task automatic send_frame(input int npre, input int gap, input logic crc_bad);
    int    len;
    int    n;
    logic  err;
    beat_t b;
    len = frm.size();
    n   = 0;
    err = 1'b0;
    if (len > MaxF) begin
      n   = MaxF + 1 - 5;
      err = 1'b1;
      exp_len = sat(exp_len);
    end else begin
      if (len >= 5) begin
        n   = len - 4;
        err = (len < MinF) || crc_bad;
      end
      if (len < MinF) exp_len = sat(exp_len);
      else if (crc_bad) exp_crc = sat(exp_crc);
      else exp_ok = sat(exp_ok);
    end
    for (int k = 0; k < n; k++) begin
      b.d    = frm[k];
      b.last = (k == n - 1);
      b.err  = (k == n - 1) && err;
      exp_q.push_back(b);
    end
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, frm[i]);
      if (i == 0) check("busy_in_frame", rx_busy, 1);
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_ok"}, cnt_ok, exp_ok);
    check({tag, "_crc"}, cnt_crc_err, exp_crc);
    check({tag, "_len"}, cnt_len_err, exp_len);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", rx_data, e.d);
          check("beat_last", rx_last, e.last);
          check("beat_err", rx_err, e.err);
        end
      end else if (rx_last || rx_err) begin
        check("flags_without_valid", {rx_last, rx_err}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_last", rx_last, 0);
    check("rst_err", rx_err, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_cnt", {cnt_ok, cnt_crc_err, cnt_len_err}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 8'h00);

    // 1: good 64-byte frame
    make_frame(60, 0, -1);
    send_frame(7, 2, 1'b0);
    settle_and_check("t1");

    // 2: payload byte 10 corrupted after FCS generation
    make_frame(60, 0, 10);
    send_frame(7, 2, 1'b1);
    settle_and_check("t2");

    // 3: runt with valid FCS
    make_frame(36, 0, -1);
    send_frame(7, 2, 1'b0);
    settle_and_check("t3");

    // 4: oversize 1600-byte frame
    make_frame(1596, 0, -1);
    send_frame(7, 2, 1'b0);
    settle_and_check("t4");

    // 5: reset mid-frame with dv held high
    make_frame(60, 8'h20, -1);
    for (int k = 0; k < 15; k++) begin
      e.d = frm[k]; e.last = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, frm[i]);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    check("t5_pre_reset_beats", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_ok = 0; exp_crc = 0; exp_len = 0;
    check("t5_cnt_cleared", {cnt_ok, cnt_crc_err, cnt_len_err}, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 1) ? 8'hD5 : 8'(20 + i));
      check("t5_busy_locked_out", rx_busy, 0);
    end
    drive(1'b0, 8'h00);
    make_frame(60, 8'h80, -1);
    send_frame(7, 2, 1'b0);
    settle_and_check("t5");

    // 6: broken preamble, then two back-to-back good frames
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h12);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    settle_and_check("t6_garbage");
    make_frame(60, 0, -1);
    send_frame(7, 1, 1'b0);
    make_frame(60, 8'h40, -1);
    send_frame(7, 1, 1'b0);
    settle_and_check("t6");

    // 7: saturate cnt_ok
    for (int f = 0; f < (1 << CntW) + 3; f++) begin
      make_frame(60, f, -1);
      send_frame(2, 1, 1'b0);
    end
    settle_and_check("t7");
    check("t7_sat", cnt_ok, CntMax);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
